// File: rtl/vram_dpram_21kx32.sv
`default_nettype none
// vram_dpram_21kx32: 21504 x 32 true dual-port video RAM, read-first on both ports,
// port A wins a same-address dual write. Rev 1.0
module vram_dpram_21kx32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int DEPTH      = 21504
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  wren_a,
  input  logic                  rden_a,
  output logic [DATA_WIDTH-1:0] q_a,
  input  logic [ADDR_WIDTH-1:0] address_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  wren_b,
  input  logic                  rden_b,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic in_range_a;
  logic in_range_b;
  logic write_a;
  logic write_b;

  always_comb begin
    in_range_a = ({1'b0, address_a} < LIMIT);
    in_range_b = ({1'b0, address_b} < LIMIT);
    write_a    = wren_a && in_range_a && !reset;
    // Port B's write is dropped outright when it collides with a port A write.
    write_b    = wren_b && in_range_b && !reset &&
                 !(write_a && (address_a == address_b));
  end

  always_ff @(posedge clk) begin
    if (write_a) mem[address_a] <= data_a;
    if (write_b) mem[address_b] <= data_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_a <= '0;
    end else if (rden_a) begin
      q_a <= in_range_a ? mem[address_a] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_b <= '0;
    end else if (rden_b) begin
      q_b <= in_range_b ? mem[address_b] : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vram_dpram_21kx32.sv
`default_nettype none
// tb_vram_dpram_21kx32: directed scenarios plus randomized traffic against an array-based reference.
module tb_vram_dpram_21kx32;

  localparam int DW = 32;
  localparam int AW = 15;
  localparam int DEPTH = 21504;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address_a = '0;
  logic [DW-1:0] data_a = '0;
  logic          wren_a = 1'b0;
  logic          rden_a = 1'b0;
  logic [DW-1:0] q_a;
  logic [AW-1:0] address_b = '0;
  logic [DW-1:0] data_b = '0;
  logic          wren_b = 1'b0;
  logic          rden_b = 1'b0;
  logic [DW-1:0] q_b;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_qa = '0;
  logic [DW-1:0] exp_qb = '0;

  vram_dpram_21kx32 dut (
    .clk       (clk),
    .reset     (reset),
    .address_a (address_a),
    .data_a    (data_a),
    .wren_a    (wren_a),
    .rden_a    (rden_a),
    .q_a       (q_a),
    .address_b (address_b),
    .data_b    (data_b),
    .wren_b    (wren_b),
    .rden_b    (rden_b),
    .q_b       (q_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the reference, then compare both outputs.
  task automatic step(input logic rst,
                      input logic wa, input logic ra, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input logic wb, input logic rb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    reset = rst;
    wren_a = wa; rden_a = ra; address_a = aa; data_a = da;
    wren_b = wb; rden_b = rb; address_b = ab; data_b = db;
    @(posedge clk);
    if (rst) begin
      exp_qa = '0;
      exp_qb = '0;
    end else begin
      if (ra) exp_qa = (int'(aa) < DEPTH) ? ref_mem[aa] : '0;
      if (rb) exp_qb = (int'(ab) < DEPTH) ? ref_mem[ab] : '0;
      if (wb && int'(ab) < DEPTH) ref_mem[ab] = db;
      if (wa && int'(aa) < DEPTH) ref_mem[aa] = da;
    end
    #1;
    check("q_a", q_a, exp_qa);
    check("q_b", q_b, exp_qb);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return AW'($urandom_range(0, 7));
      1:       return AW'($urandom_range(21500, 21510));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset_q_a", q_a, 32'h0);
    check("reset_q_b", q_b, 32'h0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    check("powerup_zero", q_a, 32'h0);

    step(0, 1, 0, 100, 32'hDEADBEEF, 0, 0, 0, 0);
    step(0, 0, 1, 100, 0, 0, 0, 0, 0);
    check("a_write_read", q_a, 32'hDEADBEEF);
    step(0, 0, 0, 100, 0, 0, 0, 0, 0);
    check("a_hold", q_a, 32'hDEADBEEF);

    step(0, 1, 0, 21503, 32'h12345678, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 21503, 0);
    check("b_top_word", q_b, 32'h12345678);
    step(0, 0, 0, 0, 0, 0, 1, 21504, 0);
    check("b_unmapped", q_b, 32'h0);
    step(0, 1, 0, 21504, 32'hFFFFFFFF, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 21503, 0);
    check("no_alias_0", q_a, 32'h0);
    check("no_alias_top", q_b, 32'h12345678);

    step(0, 1, 0, 5, 32'hAAAAAAAA, 0, 0, 0, 0);
    step(0, 1, 0, 5, 32'h55555555, 0, 1, 5, 0);
    check("cross_read_first", q_b, 32'hAAAAAAAA);
    step(0, 0, 0, 0, 0, 0, 1, 5, 0);
    check("cross_new_data", q_b, 32'h55555555);

    step(0, 1, 0, 7, 32'h1, 1, 0, 7, 32'h2);
    step(0, 0, 1, 7, 0, 0, 1, 7, 0);
    check("dual_write_a_wins", q_a, 32'h1);

    step(0, 0, 1, 100, 0, 0, 0, 0, 0);
    check("pre_reset_q_a", q_a, 32'hDEADBEEF);
    step(1, 1, 0, 100, 32'h99, 0, 0, 0, 0);
    check("midreset_clear", q_a, 32'h0);
    step(0, 0, 1, 100, 0, 0, 0, 0, 0);
    check("midreset_write_lost", q_a, 32'hDEADBEEF);

    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] aa;
      logic [AW-1:0] ab;
      aa = pick_addr();
      ab = ($urandom_range(0, 3) == 0) ? aa : pick_addr();
      step(($urandom_range(0, 49) == 0),
           1'($urandom), 1'($urandom), aa, $urandom,
           1'($urandom), 1'($urandom), ab, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_dpram_21kx32.md
Name: vram_dpram_21kx32

Overview:
- Single-clock, true dual-port 21504 x 32-bit video RAM.
- Port A is the CPU side (read/write). Port B is the display-fetch side; it is normally read-only but has full write capability.
- Sits inside the RAM controller between the CPU vram interface and the VGA scan-out logic. The controller adds its own ready-delay pipelines around this block.

Parameters:
- DATA_WIDTH, 32, word width of both ports.
- ADDR_WIDTH, 15, address width of both ports.
- DEPTH, 21504, number of implemented words (21 x 1024). Addresses at or above DEPTH are unmapped.

Ports:
- clk  input  1  single clock for both ports; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- address_a  input  ADDR_WIDTH  port A word address.
- data_a  input  DATA_WIDTH  port A write data.
- wren_a  input  1  port A write enable.
- rden_a  input  1  port A read enable.
- q_a  output  DATA_WIDTH  port A registered read data.
- address_b  input  ADDR_WIDTH  port B word address.
- data_b  input  DATA_WIDTH  port B write data.
- wren_b  input  1  port B write enable.
- rden_b  input  1  port B read enable.
- q_b  output  DATA_WIDTH  port B registered read data.

Behaviour:
- Storage: DEPTH words, all initialised to 0 at configuration/power-up. Reset does not clear storage.
- Reset: while reset=1 at a rising edge:
  - q_a and q_b become 0.
  - Both writes are suppressed.
  - Reads are not performed.
- Read, per port (independent):
  - If rden=1 at a rising edge, q takes mem[address] at that edge. Latency is 1 cycle: data is valid the cycle after rden is sampled.
  - If rden=0, q holds its previous value.
  - If address >= DEPTH, q takes 0.
- Write, per port:
  - If wren=1 and address < DEPTH at a rising edge, mem[address] <= data.
  - A write to address >= DEPTH is ignored; no aliasing.
  - wren and rden are independent and may both be 1.
- Same-port read and write to the same address in one cycle: read-first. q gets the old contents; the new data is visible on the next read.
- Cross-port, same address, same cycle:
  - One port reads while the other writes: the reader gets the old contents (read-first).
  - Both ports write: port A's data is stored; port B's write is dropped.
- Different addresses: both ports operate fully concurrently every cycle, with no stalls and no arbitration.
- No handshake outputs. Callers wait a fixed 1 cycle after rden before sampling q.
- Reset asserted mid-operation: q is cleared on the reset edge and any write presented on that edge is lost. Operation resumes on the first edge after reset deasserts.
- Widths: addresses are unsigned and compared against DEPTH as unsigned. No arithmetic on data.
- Implementation must infer block RAM: one registered read per port, no asynchronous reads of the array. The q-output registers may be outside the array.

Test Plan:
- Reset then read: reset=1 for 2 cycles -> q_a=0 and q_b=0. Then read address_a=0 with rden_a=1 -> q_a=0 one cycle later (power-up zero).
- Basic write/read on port A: write 0xDEADBEEF at address 100, next cycle rden_a=1 at 100 -> q_a=0xDEADBEEF one cycle later. With rden_a=0 afterwards, q_a holds 0xDEADBEEF.
- Cross-port visibility: port A writes 0x12345678 at address 21503 -> port B read of 21503 next cycle gives q_b=0x12345678. Port B read of 21504 gives q_b=0. A port A write of 0xFFFFFFFF to 21504 leaves mem[0..21503] unchanged; check addresses 0 and 21503.
- Read-first collision: mem[5]=0xAAAAAAAA. In one cycle, port A writes 0x55555555 at 5 while port B reads 5 -> q_b=0xAAAAAAAA. The next port B read of 5 gives 0x55555555.
- Dual-write collision: both ports write address 7 in the same cycle, A=0x1, B=0x2 -> subsequent read of 7 gives 0x1.
- Reset mid-operation: q_a=0xDEADBEEF. Assert reset on the same edge as a port A write of 0x99 to address 100 -> q_a=0, and a later read of 100 still returns 0xDEADBEEF (storage kept, write dropped).
